// File: rtl/unum_mac_if.sv
// Bus bundle for unum_mac: run control, operands, configuration and result.
// Handshake: valid is a one-cycle qualifier on out0 with no backpressure;
// every cycle with valid=1 carries exactly one new result, and out0 holds
// its previous value whenever valid=0. There is no ready signal.
interface unum_mac_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 32
);
  logic               running;
  logic               run;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  in1;
  logic [DELAY_W-1:0] delay0;
  logic [DELAY_W-1:0] period;
  logic [1:0]         mode;
  logic               sat;
  logic [DATA_W-1:0]  out0;
  logic               valid;
  logic [1:0]         dbg_state;

  modport master (
    output running, run, in0, in1, delay0, period, mode, sat,
    input  out0, valid, dbg_state
  );

  modport slave (
    input  running, run, in0, in1, delay0, period, mode, sat,
    output out0, valid, dbg_state
  );
endinterface

// File: rtl/unum_mac.sv
// Streaming add/sub/accumulate/multiply-accumulate unit with optional signed
// saturation, a start delay, periodic accumulator clear and LAT-cycle latency.
module unum_mac #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 32,
  parameter int LAT     = 2
) (
  input logic       clk,
  input logic       rst,
  unum_mac_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0]         MODE_ADD = 2'd0;
  localparam logic [1:0]         MODE_SUB = 2'd1;
  localparam logic [1:0]         MODE_ACC = 2'd2;
  localparam logic [DELAY_W-1:0] ONE_D    = 1;
  localparam logic [DATA_W-1:0]  MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]  MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t             r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_cnt, w_cnt_nxt;
  logic [DELAY_W-1:0] r_period;
  logic [DELAY_W-1:0] r_k;
  logic [DELAY_W-1:0] r_phase, w_phase_nxt;
  logic [1:0]         r_mode;
  logic               r_sat;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_data [LAT];
  logic [LAT-1:0]     r_vld;

  logic               w_start;
  logic               w_consume;
  logic               w_flush;
  logic [DATA_W-1:0]  w_acc_in;
  logic [DATA_W-1:0]  w_prod;
  logic [DATA_W-1:0]  w_lhs, w_rhs;
  logic               w_sub;
  logic [DATA_W:0]    w_lhs_e, w_rhs_e, w_sum_e;
  logic               w_ovf;
  logic [DATA_W-1:0]  w_res;

  // A run pulse only counts while running; it restarts from any state.
  assign w_start   = bus.run & bus.running;
  // The run cycle itself never consumes a sample, even on a restart.
  assign w_consume = (r_state == S_ACTIVE) & bus.running & ~bus.run;
  // Dropping running or restarting discards everything still in the pipe.
  assign w_flush   = ~bus.running | w_start;

  // The low DATA_W bits of a signed product equal those of the unsigned one.
  assign w_prod   = bus.in0 * bus.in1;
  assign w_acc_in = ((r_period != '0) && (r_phase == '0)) ? '0 : r_acc;

  // Next state and delay counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!bus.running) begin
      w_state_nxt = S_IDLE;
    end else if (bus.run) begin
      if (bus.delay0 == '0) begin
        w_state_nxt = S_ACTIVE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = S_DELAY;
        w_cnt_nxt   = bus.delay0 - ONE_D;
      end
    end else begin
      case (r_state)
        S_DELAY: begin
          if (r_cnt == '0) w_state_nxt = S_ACTIVE;
          else             w_cnt_nxt   = r_cnt - ONE_D;
        end
        default: ;
      endcase
    end
  end

  // Operand selection and the single shared saturating adder.
  always_comb begin
    w_lhs = bus.in0;
    w_rhs = bus.in1;
    w_sub = 1'b0;
    case (r_mode)
      MODE_ADD: ;
      MODE_SUB: w_sub = 1'b1;
      MODE_ACC: begin
        w_lhs = w_acc_in;
        w_rhs = bus.in0;
      end
      default: begin
        w_lhs = w_acc_in;
        w_rhs = w_prod;
      end
    endcase
    w_lhs_e = {w_lhs[DATA_W-1], w_lhs};
    w_rhs_e = {w_rhs[DATA_W-1], w_rhs};
    w_sum_e = w_sub ? (w_lhs_e - w_rhs_e) : (w_lhs_e + w_rhs_e);
    w_ovf   = w_sum_e[DATA_W] ^ w_sum_e[DATA_W-1];
    w_res   = w_sum_e[DATA_W-1:0];
    if (r_sat && w_ovf) w_res = w_sum_e[DATA_W] ? MIN_NEG : MAX_POS;
  end

  // Phase tracks k mod period; it restarts whenever k wraps to zero.
  always_comb begin
    w_phase_nxt = r_phase + ONE_D;
    if ((&r_k) || (r_phase == r_period - ONE_D)) w_phase_nxt = '0;
  end

  // FSM, configuration latch, sample index and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_k      <= '0;
      r_phase  <= '0;
      r_mode   <= '0;
      r_sat    <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) begin
        r_mode   <= bus.mode;
        r_sat    <= bus.sat;
        r_period <= bus.period;
        r_acc    <= '0;
        r_k      <= '0;
        r_phase  <= '0;
      end else if (w_consume) begin
        r_k     <= r_k + ONE_D;
        r_phase <= w_phase_nxt;
        if (r_mode[1]) r_acc <= w_res;
      end
    end
  end

  // Result pipeline: stage 0 is the acc update, stage LAT-1 drives out0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_data[i] <= '0;
    end else if (w_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_consume;
      if (w_consume) r_data[0] <= w_res;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign bus.out0      = r_data[LAT-1];
  assign bus.valid     = r_vld[LAT-1];
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_unum_mac.sv
// Bench for unum_mac: a 32-bit LAT=2 and an 8-bit LAT=1 instance share one
// stimulus stream; a behavioural model predicts each result and its cycle.
module tb_unum_mac;

  localparam int LAT32 = 2;
  localparam int LAT8  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        running, run, sat;
  logic [1:0]  mode;
  logic [31:0] in0, in1, delay0, period;

  unum_mac_if #(.DATA_W(32), .DELAY_W(32)) bus32 ();
  unum_mac_if #(.DATA_W(8),  .DELAY_W(32)) bus8 ();

  assign bus32.running = running;
  assign bus32.run     = run;
  assign bus32.in0     = in0;
  assign bus32.in1     = in1;
  assign bus32.delay0  = delay0;
  assign bus32.period  = period;
  assign bus32.mode    = mode;
  assign bus32.sat     = sat;
  assign bus8.running  = running;
  assign bus8.run      = run;
  assign bus8.in0      = in0[7:0];
  assign bus8.in1      = in1[7:0];
  assign bus8.delay0   = delay0;
  assign bus8.period   = period;
  assign bus8.mode     = mode;
  assign bus8.sat      = sat;

  unum_mac #(.DATA_W(32), .DELAY_W(32), .LAT(LAT32)) u_dut32 (
    .clk (clk), .rst (rst), .bus (bus32)
  );
  unum_mac #(.DATA_W(8), .DELAY_W(32), .LAT(LAT8)) u_dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int rc = 0;

  logic [31:0] exp32_q[$];
  int          due32_q[$];
  logic [31:0] exp8_q[$];
  int          due8_q[$];
  logic [31:0] obs0_q[$];
  int          obsc0_q[$];
  logic [31:0] obs1_q[$];
  int          obsc1_q[$];
  logic [31:0] last_out[2];

  // ---------------- behavioural model ----------------
  logic [1:0] m_mode;
  bit         m_sat;
  longint     m_period;
  longint     m_k;
  longint     m_acc[2];

  function automatic longint sx(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic longint fix(input longint v, input int w, input bit s);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (!s) return sx(v, w);
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic model_step(input int d, input logic [31:0] a_raw,
                            input logic [31:0] b_raw, output logic [31:0] res);
    int w;
    longint a, b, acc_in, r;
    logic [63:0] u;
    w = (d == 0) ? 32 : 8;
    a = sx(longint'(a_raw), w);
    b = sx(longint'(b_raw), w);
    acc_in = (m_period != 0 && (m_k % m_period) == 0) ? 0 : m_acc[d];
    case (m_mode)
      2'd0:    r = fix(a + b, w, m_sat);
      2'd1:    r = fix(a - b, w, m_sat);
      2'd2:    r = fix(acc_in + a, w, m_sat);
      default: r = fix(acc_in + sx(a * b, w), w, m_sat);
    endcase
    if (m_mode[1]) m_acc[d] = r;
    u = r;
    res = (d == 0) ? u[31:0] : {24'b0, u[7:0]};
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic lit(input string name, input int d, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = 32'hBAD0_BAD0;
    if (d == 0) begin
      if (idx < obs0_q.size()) got = obs0_q[idx];
    end else begin
      if (idx < obs1_q.size()) got = obs1_q[idx];
    end
    chk(name, got, exp);
  endtask

  task automatic lit_cyc(input string name, input int d, input int offset);
    int got;
    got = -1;
    if (d == 0 && obsc0_q.size() > 0) got = obsc0_q[0] - rc;
    if (d == 1 && obsc1_q.size() > 0) got = obsc1_q[0] - rc;
    chk(name, 32'(got), 32'(offset));
  endtask

  task automatic check_out(input int d, input logic v, input logic [31:0] o);
    logic        hit;
    logic [31:0] e;
    hit = 1'b0;
    e   = '0;
    if (d == 0) begin
      if (due32_q.size() > 0 && due32_q[0] == cyc) begin
        hit = 1'b1;
        e   = exp32_q.pop_front();
        void'(due32_q.pop_front());
      end
      if (v) begin obs0_q.push_back(o); obsc0_q.push_back(cyc); end
    end else begin
      if (due8_q.size() > 0 && due8_q[0] == cyc) begin
        hit = 1'b1;
        e   = exp8_q.pop_front();
        void'(due8_q.pop_front());
      end
      if (v) begin obs1_q.push_back(o); obsc1_q.push_back(cyc); end
    end
    if (hit) begin
      chk((d == 0) ? "valid32" : "valid8", 32'(v), 32'd1);
      chk((d == 0) ? "out32" : "out8", o, e);
      last_out[d] = e;
    end else begin
      chk((d == 0) ? "idle_valid32" : "idle_valid8", 32'(v), 32'd0);
      chk((d == 0) ? "hold_out32" : "hold_out8", o, last_out[d]);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_out(0, bus32.valid, bus32.out0);
      check_out(1, bus8.valid, {24'b0, bus8.out0});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp32_q.delete(); due32_q.delete();
    exp8_q.delete();  due8_q.delete();
  endtask

  task automatic push_sample(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    in0 = a;
    in1 = b;
    model_step(0, a, b, r); exp32_q.push_back(r); due32_q.push_back(cyc + LAT32);
    model_step(1, a, b, r); exp8_q.push_back(r);  due8_q.push_back(cyc + LAT8);
    m_k++;
    tick();
  endtask

  task automatic start(input logic [1:0] md, input bit st, input int per, input int dly);
    running = 1'b1;
    run     = 1'b1;
    mode    = md;
    sat     = st;
    period  = 32'(per);
    delay0  = 32'(dly);
    rc      = cyc;
    tick();
    run    = 1'b0;
    mode   = 2'($urandom_range(0, 3));
    sat    = 1'($urandom_range(0, 1));
    period = $urandom_range(0, 9);
    delay0 = $urandom_range(0, 9);
    clear_exp();
    obs0_q.delete(); obsc0_q.delete(); obs1_q.delete(); obsc1_q.delete();
    m_mode = md; m_sat = st; m_period = per; m_k = 0;
    m_acc[0] = 0; m_acc[1] = 0;
    for (int i = 1; i <= dly; i++) begin
      in0 = 32'(i);
      in1 = '0;
      tick();
    end
  endtask

  task automatic stop();
    for (int i = 0; i < 3; i++) push_sample($urandom_range(0, 255), $urandom_range(0, 255));
    running = 1'b0;
    tick();
    clear_exp();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    running = 0; run = 0; mode = 0; sat = 0; in0 = 0; in1 = 0;
    delay0 = 0; period = 0; rst = 1'b1;
    last_out[0] = '0; last_out[1] = '0;
    repeat (3) tick();
    chk("rst_valid32", 32'(bus32.valid), 32'd0);
    chk("rst_out32", bus32.out0, 32'd0);
    chk("rst_valid8", 32'(bus8.valid), 32'd0);
    chk("rst_out8", {24'b0, bus8.out0}, 32'd0);
    chk("rst_state32", 32'(bus32.dbg_state), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();

    // ADD, no delay: 5+7 two cycles after run (LAT=1), three (LAT=2).
    start(2'd0, 1'b0, 0, 0);
    push_sample(32'd5, 32'd7);
    stop();
    lit("add8", 1, 0, 32'd12);
    lit_cyc("add8_cyc", 1, 2);
    lit("add32", 0, 0, 32'd12);
    lit_cyc("add32_cyc", 0, 3);

    // ADD with delay0=3: cycles 1-3 ignored, first result 4 at cycle 6.
    start(2'd0, 1'b0, 0, 3);
    push_sample(32'd4, 32'd0);
    push_sample(32'd5, 32'd0);
    push_sample(32'd6, 32'd0);
    stop();
    lit("dly32_first", 0, 0, 32'd4);
    lit_cyc("dly32_cyc", 0, 6);
    lit("dly32_second", 0, 1, 32'd5);
    lit_cyc("dly8_cyc", 1, 5);

    // ACC with period 4.
    start(2'd2, 1'b0, 4, 0);
    for (int i = 1; i <= 6; i++) push_sample(32'(i), $urandom_range(0, 255));
    stop();
    lit("acc32_0", 0, 0, 32'd1);
    lit("acc32_1", 0, 1, 32'd3);
    lit("acc32_2", 0, 2, 32'd6);
    lit("acc32_3", 0, 3, 32'd10);
    lit("acc32_4", 0, 4, 32'd5);
    lit("acc32_5", 0, 5, 32'd11);
    lit("acc8_5", 1, 5, 32'd11);

    // SUB at the negative limit, saturating then wrapping.
    start(2'd1, 1'b1, 0, 0);
    push_sample(32'h80, 32'h01);
    stop();
    lit("sub8_sat", 1, 0, 32'h80);
    lit("sub32_sat", 0, 0, 32'h7F);
    start(2'd1, 1'b0, 0, 0);
    push_sample(32'h80, 32'h01);
    stop();
    lit("sub8_wrap", 1, 0, 32'h7F);

    // MAC, never cleared.
    start(2'd3, 1'b0, 0, 0);
    push_sample(32'd3, 32'd4);
    push_sample(32'd3, 32'd4);
    push_sample(32'hFFFF_FFFE, 32'd5);
    stop();
    lit("mac32_0", 0, 0, 32'd12);
    lit("mac32_1", 0, 1, 32'd24);
    lit("mac32_2", 0, 2, 32'd14);
    lit("mac8_2", 1, 2, 32'd14);

    // MAC with saturation on the 8-bit instance.
    start(2'd3, 1'b1, 0, 0);
    push_sample(32'd100, 32'd1);
    push_sample(32'd100, 32'd1);
    stop();
    lit("macsat8_0", 1, 0, 32'd100);
    lit("macsat8_1", 1, 1, 32'd127);
    lit("macsat32_1", 0, 1, 32'd200);

    // Restart during an ACTIVE MAC stream: acc and index start over.
    start(2'd3, 1'b0, 3, 2);
    push_sample(32'd7, 32'hFFFF_FFFD);
    push_sample(32'd2, 32'd9);
    push_sample(32'd11, 32'd13);
    push_sample(32'd1, 32'd1);
    start(2'd2, 1'b0, 0, 0);
    push_sample(32'd10, 32'd0);
    push_sample(32'd20, 32'd0);
    stop();
    lit("restart32_0", 0, 0, 32'd10);
    lit("restart32_1", 0, 1, 32'd30);

    // running dropped mid-stream: valid stops, out0 holds.
    start(2'd2, 1'b0, 0, 0);
    for (int i = 1; i <= 4; i++) push_sample(32'(i), 32'd0);
    running = 1'b0;
    tick();
    clear_exp();
    repeat (2) tick();
    chk("drop_hold32", bus32.out0, 32'd6);
    chk("drop_hold8", {24'b0, bus8.out0}, 32'd10);
    chk("drop_valid32", 32'(bus32.valid), 32'd0);
    // run while not running is ignored.
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (4) begin
      in0 = $urandom_range(0, 255);
      tick();
    end
    chk("ignored_run_state32", 32'(bus32.dbg_state), 32'd0);

    // Reset mid-stream: outputs cleared, nothing until a new run.
    start(2'd3, 1'b1, 2, 1);
    for (int i = 3; i <= 6; i++) push_sample(32'(i), 32'(i));
    rst = 1'b1;
    tick();
    clear_exp();
    last_out[0] = '0;
    last_out[1] = '0;
    chk("midrst_out32", bus32.out0, 32'd0);
    chk("midrst_valid32", 32'(bus32.valid), 32'd0);
    chk("midrst_out8", {24'b0, bus8.out0}, 32'd0);
    chk("midrst_valid8", 32'(bus8.valid), 32'd0);
    rst = 1'b0;
    repeat (4) begin
      in0 = $urandom_range(0, 255);
      in1 = $urandom_range(0, 255);
      tick();
    end
    start(2'd0, 1'b0, 0, 0);
    push_sample(32'd1, 32'd2);
    stop();
    lit("post_rst_add32", 0, 0, 32'd3);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit so the run always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
